seg14_scan_decoder: RTL and testbench
=====================================

Name: seg14_scan_decoder

Overview:
Receive-side companion to the team's 12-digit 14-segment scan drivers. It samples the multiplexed display bus: a one-hot digit select plus a 14-bit segment pattern, presented one digit per clock. It decodes each pattern back to a 4-bit character code, checks scan order, and assembles complete frames in a double-buffered character store. Used on-chip as a self-check monitor for display drivers and as a readback path for the test harness.

Parameters:
DIGITS, 12, number of digit positions; sel width; index range 0..DIGITS-1.
SEGW, 14, segment pattern width, bit 13 = segment a (MSB), matching the driver patterns.

Ports:
clk  input  1  system clock; bus inputs are synchronous to it.
rst  input  1  asynchronous active-high reset.
vdd/vss  inout  1  power pins, present only under USE_POWER_PINS.
sel_in  input  DIGITS  one-hot digit select from the scan driver.
segm_in  input  SEGW  segment pattern for the selected digit.
clr_err  input  1  single-cycle pulse; clears the sticky error flags.
rd_addr  input  4  committed-buffer read index.
rd_char  output  4  registered character code at rd_addr.
frame_valid  output  1  high once at least one full frame has been committed.
frame_stb  output  1  one-cycle pulse on each frame commit.
frame_count  output  8  number of committed frames, mod 256.
err_sel  output  1  sticky: sel_in was nonzero and not one-hot.
err_char  output  1  sticky: a segment pattern was not in the decode table.
err_order  output  1  sticky: a digit arrived out of sequence.

Behaviour:
- Reset (async, immediate):
  - Both buffers set to 0 (space).
  - rd_char=0, frame_valid=0, frame_stb=0, frame_count=0, all errors 0.
  - FSM in HUNT, expected=0, last index invalid.
  - Reset asserted mid-frame discards the partial capture.
- Pipeline:
  - Stage 1 registers sel_in/segm_in.
  - Stage 2 decodes, checks order, writes the capture buffer, and updates the FSM.
  - frame_stb and error flags are visible the cycle after stage 2, i.e. 2 edges after the last digit is presented.
- Decode table (pattern -> code):
  - 00000000000000->0 (space)
  - 10011110000000->1 (E)
  - 10001110000000->2 (F)
  - 00011100000000->3 (L)
  - 11111100000000->4 (O)
  - 11001111000100->5 (R)
  - 10110111000000->6 (S)
  - 10000000010010->7 (T)
  - 01111100000000->8 (U)
  - Any other pattern -> code 15 and sets err_char; the code is still written.
- Select handling:
  - sel=0: idle cycle, no write, no error, state unchanged.
  - Multi-hot sel: set err_sel, no write; the FSM goes to HUNT.
  - One-hot sel: index k = bit position.
- FSM HUNT:
  - k=0: write capture[0], expected=1, go to TRACK.
  - Any other k: ignored, no error.
- FSM TRACK:
  - k==last accepted index (dwell): overwrite that capture entry; no error.
  - k==expected: write capture[k], expected=k+1.
  - k==DIGITS-1 accepted: commit. The committed buffer takes the full capture, including this digit, in the same edge. Pulse frame_stb, set frame_valid=1, frame_count+1 (255 wraps to 0), go to HUNT.
  - Other k: set err_order, go to HUNT. The partial capture is not committed. If k==0, treat it as a new frame start: write capture[0], expected=1, stay in TRACK.
- Back-to-back frames: digit 0 in the cycle immediately after a commit is accepted; no gap is needed.
- Read port:
  - rd_char <= committed[rd_addr] each edge, so 1-cycle latency.
  - rd_addr >= DIGITS returns 0.
  - Reading during a commit edge returns the pre-commit value.
- Errors:
  - Sticky until clr_err.
  - Error event coincident with clr_err leaves that flag set.
  - Errors never block capture of later frames.

Test Plan:
- Scan sequence E,L,sp,F,U,T,U,R,O,sp,E,S on indices 0..11, one per cycle -> frame_stb once 2 edges after index 11; reading rd_addr 0..11 gives 1,3,0,2,8,7,8,5,4,0,1,6; frame_count=1; no errors.
- Same frame with idle cycles (sel=0) between digits, and index 4 held 3 cycles -> identical committed codes, no errors.
- Index 5 skipped (4 then 6) -> err_order=1, no frame_stb, committed buffer unchanged. The next clean 0..11 pass commits normally; frame_count increments by 1.
- sel_in=12'h003 mid-frame -> err_sel=1, no write, FSM to HUNT. segm_in=14'h3FFF at index 2 -> code 15 read at addr 2 after commit, err_char=1. clr_err clears both.
- 256 clean frames -> frame_count wraps to 0, frame_valid stays 1. rd_addr=13 -> rd_char=0.
- Assert rst for 1 cycle at index 7 -> all outputs 0 immediately; the next full scan commits correctly from HUNT.

Source files
------------

// File: rtl/seg14_scan_decoder.sv
// Scan-bus monitor for 14-segment multiplexed displays: decodes each digit pattern,
// checks scan order and commits complete frames into a readable character store.
module seg14_scan_decoder #(
  parameter int DIGITS = 12,
  parameter int SEGW   = 14
) (
`ifdef USE_POWER_PINS
  inout  wire              vdd,
  inout  wire              vss,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic [DIGITS-1:0] sel_in,
  input  logic [SEGW-1:0]   segm_in,
  input  logic              clr_err,
  input  logic [3:0]        rd_addr,
  output logic [3:0]        rd_char,
  output logic              frame_valid,
  output logic              frame_stb,
  output logic [7:0]        frame_count,
  output logic              err_sel,
  output logic              err_char,
  output logic              err_order
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     expected_reg, expected_next;
  logic [IW-1:0]     last_reg, last_next;
  logic [DIGITS-1:0] sel_reg;
  logic [SEGW-1:0]   segm_reg;
  logic              frame_stb_reg, frame_valid_reg;
  logic [7:0]        frame_count_reg;
  logic              err_sel_reg, err_char_reg, err_order_reg;
  logic [3:0]        rd_char_reg;

  logic              onehot, multihot;
  logic [IW-1:0]     k_idx;
  logic [3:0]        code;
  logic              bad_pat;
  logic              wr_en, commit, ev_order;
  logic [3:0]        capture_w   [DIGITS];
  logic [3:0]        committed_w [DIGITS];

  // Select classification and bit-position of a one-hot select.
  always_comb begin
    onehot   = (sel_reg != '0) && ((sel_reg & (sel_reg - DIGITS'(1))) == '0);
    multihot = (sel_reg != '0) && !onehot;
    k_idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_reg[i]) k_idx = IW'(i);
    end
  end

  always_comb begin
    code    = 4'd15;
    bad_pat = 1'b0;
    case (segm_reg)
      14'b00000000000000: code = 4'd0;
      14'b10011110000000: code = 4'd1;
      14'b10001110000000: code = 4'd2;
      14'b00011100000000: code = 4'd3;
      14'b11111100000000: code = 4'd4;
      14'b11001111000100: code = 4'd5;
      14'b10110111000000: code = 4'd6;
      14'b10000000010010: code = 4'd7;
      14'b01111100000000: code = 4'd8;
      default:            bad_pat = 1'b1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    last_next     = last_reg;
    wr_en         = 1'b0;
    commit        = 1'b0;
    ev_order      = 1'b0;
    if (multihot) begin
      state_next    = HUNT;
      expected_next = '0;
    end else if (onehot) begin
      case (state_reg)
        HUNT: begin
          if (k_idx == '0) begin
            wr_en         = 1'b1;
            expected_next = IW'(1);
            last_next     = '0;
            state_next    = TRACK;
          end
        end
        TRACK: begin
          if (k_idx == last_reg) begin
            wr_en = 1'b1;
          end else if (k_idx == expected_reg) begin
            wr_en     = 1'b1;
            last_next = k_idx;
            if (k_idx == IW'(DIGITS - 1)) begin
              commit        = 1'b1;
              expected_next = '0;
              state_next    = HUNT;
            end else begin
              expected_next = k_idx + IW'(1);
            end
          end else begin
            // Out-of-order digit; a digit 0 doubles as the start of a fresh frame.
            ev_order      = 1'b1;
            expected_next = '0;
            state_next    = HUNT;
            if (k_idx == '0) begin
              wr_en         = 1'b1;
              expected_next = IW'(1);
              last_next     = '0;
              state_next    = TRACK;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Commit copies the capture plus the digit being written on the same edge.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_buf
      logic [3:0] cap_reg, com_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cap_reg <= '0;
          com_reg <= '0;
        end else begin
          if (wr_en && (k_idx == IW'(gi))) cap_reg <= code;
          if (commit) com_reg <= (wr_en && (k_idx == IW'(gi))) ? code : cap_reg;
        end
      end
      assign capture_w[gi]   = cap_reg;
      assign committed_w[gi] = com_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      expected_reg    <= '0;
      last_reg        <= '0;
      sel_reg         <= '0;
      segm_reg        <= '0;
      frame_stb_reg   <= 1'b0;
      frame_valid_reg <= 1'b0;
      frame_count_reg <= '0;
      err_sel_reg     <= 1'b0;
      err_char_reg    <= 1'b0;
      err_order_reg   <= 1'b0;
      rd_char_reg     <= '0;
    end else begin
      sel_reg         <= sel_in;
      segm_reg        <= segm_in;
      state_reg       <= state_next;
      expected_reg    <= expected_next;
      last_reg        <= last_next;
      frame_stb_reg   <= commit;
      frame_valid_reg <= frame_valid_reg | commit;
      frame_count_reg <= frame_count_reg + {7'd0, commit};
      err_sel_reg     <= (err_sel_reg & ~clr_err) | multihot;
      err_char_reg    <= (err_char_reg & ~clr_err) | (wr_en & bad_pat);
      err_order_reg   <= (err_order_reg & ~clr_err) | ev_order;
      rd_char_reg     <= (rd_addr < 4'(DIGITS)) ? committed_w[rd_addr[IW-1:0]] : 4'd0;
    end
  end

  assign rd_char     = rd_char_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_stb   = frame_stb_reg;
  assign frame_count = frame_count_reg;
  assign err_sel     = err_sel_reg;
  assign err_char    = err_char_reg;
  assign err_order   = err_order_reg;

  // Partial capture is observable only through commits; keep it visible for debug taps.
  logic unused_cap;
  assign unused_cap = ^{capture_w[0]};

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Randomised and directed stimulus for seg14_scan_decoder, checked every cycle against
// a frame-level reference model of the scan bus.
module tb_seg14_scan_decoder;
  logic        clk, rst, clr_err;
  logic [11:0] sel_in;
  logic [13:0] segm_in;
  logic [3:0]  rd_addr, rd_char;
  logic        frame_valid, frame_stb, err_sel, err_char, err_order;
  logic [7:0]  frame_count;

  seg14_scan_decoder dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .segm_in(segm_in), .clr_err(clr_err),
    .rd_addr(rd_addr), .rd_char(rd_char), .frame_valid(frame_valid),
    .frame_stb(frame_stb), .frame_count(frame_count), .err_sel(err_sel),
    .err_char(err_char), .err_order(err_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [13:0] pat_tab [9];
  int          msg [12] = '{1, 3, 0, 2, 8, 7, 8, 5, 4, 0, 1, 6};

  // Reference model: nxt = digits accepted so far in the current frame, -1 while hunting.
  int          m_nxt;
  logic [3:0]  m_cap [12];
  logic [3:0]  m_com [12];
  logic        m_stb, m_valid, m_esel, m_echar, m_eord;
  logic [7:0]  m_cnt;
  logic [3:0]  m_rd;
  logic [11:0] p_sel;
  logic [13:0] p_seg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_nxt = -1;
    for (int i = 0; i < 12; i++) begin m_cap[i] = 0; m_com[i] = 0; end
    m_stb = 0; m_valid = 0; m_esel = 0; m_echar = 0; m_eord = 0;
    m_cnt = 0; m_rd = 0; p_sel = 0; p_seg = 0;
  endtask

  task automatic model_edge(input logic [11:0] s, input logic [13:0] g,
                            input logic clr, input logic [3:0] ra);
    int k, code;
    logic bad, wrote, e_sel, e_ord;
    m_rd = (ra < 12) ? m_com[ra] : 4'd0;
    m_stb = 0; e_sel = 0; e_ord = 0; wrote = 0; k = 0;
    code = 15; bad = 1;
    for (int j = 0; j < 9; j++) if (p_seg == pat_tab[j]) begin code = j; bad = 0; end
    if ($countones(p_sel) > 1) begin
      e_sel = 1; m_nxt = -1;
    end else if ($countones(p_sel) == 1) begin
      for (int i = 0; i < 12; i++) if (p_sel[i]) k = i;
      if (m_nxt < 0) begin
        if (k == 0) begin m_cap[0] = 4'(code); m_nxt = 1; wrote = 1; end
      end else if (k == m_nxt - 1) begin
        m_cap[k] = 4'(code); wrote = 1;
      end else if (k == m_nxt) begin
        m_cap[k] = 4'(code); wrote = 1; m_nxt++;
        if (m_nxt == 12) begin
          for (int i = 0; i < 12; i++) m_com[i] = m_cap[i];
          m_stb = 1; m_valid = 1; m_cnt = m_cnt + 8'd1; m_nxt = -1;
        end
      end else begin
        e_ord = 1; m_nxt = -1;
        if (k == 0) begin m_cap[0] = 4'(code); m_nxt = 1; wrote = 1; end
      end
    end
    m_esel  = (m_esel & ~clr) | e_sel;
    m_eord  = (m_eord & ~clr) | e_ord;
    m_echar = (m_echar & ~clr) | (wrote & bad);
    p_sel = s; p_seg = g;
  endtask

  task automatic compare_all();
    chk("frame_stb", frame_stb, m_stb);
    chk("frame_valid", frame_valid, m_valid);
    chk("frame_count", frame_count, m_cnt);
    chk("err_sel", err_sel, m_esel);
    chk("err_char", err_char, m_echar);
    chk("err_order", err_order, m_eord);
    chk("rd_char", rd_char, m_rd);
  endtask

  task automatic cycle(input logic [11:0] s, input logic [13:0] g,
                       input logic clr, input logic [3:0] ra);
    sel_in = s; segm_in = g; clr_err = clr; rd_addr = ra;
    @(posedge clk);
    model_edge(s, g, clr, ra);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(12'h000, 14'h0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic digit(input int i, input int c);
    cycle(12'(1 << i), pat_tab[c], 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) cycle(12'h000, 14'h0, 1'b0, 4'(a));
    cycle(12'h000, 14'h0, 1'b0, 4'd13);
  endtask

  task automatic do_reset();
    rst = 1'b1; sel_in = 0; segm_in = 0; clr_err = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    pat_tab[0] = 14'b00000000000000; pat_tab[1] = 14'b10011110000000;
    pat_tab[2] = 14'b10001110000000; pat_tab[3] = 14'b00011100000000;
    pat_tab[4] = 14'b11111100000000; pat_tab[5] = 14'b11001111000100;
    pat_tab[6] = 14'b10110111000000; pat_tab[7] = 14'b10000000010010;
    pat_tab[8] = 14'b01111100000000;
    rst = 1'b1; sel_in = 0; segm_in = 0; clr_err = 0; rd_addr = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Clean message frame, then readback.
    for (int i = 0; i < 12; i++) digit(i, msg[i]);
    idle(2);
    read_all();
    for (int a = 0; a < 12; a++) begin
      cycle(12'h000, 14'h0, 1'b0, 4'(a));
      cycle(12'h000, 14'h0, 1'b0, 4'(a));
      chk("msg_readback", rd_char, 32'(msg[a]));
    end
    $display("directed frame 1 committed, count=%0d", frame_count);

    // Idle gaps and index 4 dwelling for three cycles.
    for (int i = 0; i < 12; i++) begin
      digit(i, msg[i]);
      if (i == 4) begin digit(4, msg[4]); digit(4, msg[4]); end
      idle(1);
    end
    idle(2);
    read_all();
    $display("directed frame 2 (gaps/dwell) count=%0d", frame_count);

    // Skipped index 5, then a clean pass.
    for (int i = 0; i < 5; i++) digit(i, 3);
    digit(6, 3);
    for (int i = 7; i < 12; i++) digit(i, 3);
    idle(2);
    read_all();
    for (int i = 0; i < 12; i++) digit(i, (i + 2) % 9);
    idle(2);
    read_all();
    cycle(12'h000, 14'h0, 1'b1, 4'd0);
    $display("skip test done, count=%0d", frame_count);

    // Multi-hot select mid-frame, then a frame carrying an undecodable pattern at index 2.
    digit(0, 1); digit(1, 2);
    cycle(12'h003, pat_tab[4], 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      if (i == 2) cycle(12'h004, 14'h3FFF, 1'b0, 4'd2);
      else digit(i, msg[i]);
    end
    idle(2);
    read_all();
    cycle(12'h000, 14'h0, 1'b0, 4'd2);
    cycle(12'h000, 14'h0, 1'b0, 4'd2);
    chk("bad_pattern_code", rd_char, 32'd15);
    cycle(12'h000, 14'h0, 1'b1, 4'd2);
    idle(1);
    $display("sel/char error test done, count=%0d", frame_count);

    // Randomised frames with occasional faults, dwell, gaps and error clears.
    for (int f = 0; f < 320; f++) begin
      for (int i = 0; i < 12; i++) begin
        int r;
        logic [11:0] s;
        logic [13:0] g;
        r = $urandom_range(0, 99);
        s = (r < 1) ? 12'($urandom) : 12'(1 << i);
        g = (r >= 1 && r < 4) ? 14'($urandom) : pat_tab[$urandom_range(0, 8)];
        cycle(s, g, ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 7) == 0) cycle(s, g, 1'b0, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      if (f % 32 == 0) $display("random frame %0d count=%0d", f, frame_count);
    end
    idle(2);
    read_all();

    // Reset in the middle of a frame, then a full scan from HUNT.
    for (int i = 0; i < 7; i++) digit(i, msg[i]);
    do_reset();
    chk("rst_count", frame_count, 32'd0);
    for (int i = 0; i < 12; i++) digit(i, msg[11 - i]);
    idle(2);
    read_all();
    $display("post-reset frame committed, count=%0d", frame_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
